// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: BLOCK-bit carry-lookahead groups rippled together, with a
// register after every PIPE_GROUPS groups and a single valid/ready enable for the whole pipe.
module pipelined_addsub #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned BLOCK       = 4,
    parameter int unsigned PIPE_GROUPS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int unsigned SW = BLOCK * PIPE_GROUPS;
    localparam int unsigned S  = WIDTH / SW;

    if (WIDTH == 0 || BLOCK == 0 || PIPE_GROUPS == 0 || (WIDTH % BLOCK) != 0 ||
        ((WIDTH / BLOCK) % PIPE_GROUPS) != 0) begin : g_param_check
        $fatal(1, "pipelined_addsub: WIDTH must be a multiple of BLOCK*PIPE_GROUPS");
    end

    // Each carry is a flat sum of products over g/p/cin, not a ripple through c[i].
    function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             cin);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             acc;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        acc  = 1'b0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            c[i+1] = g[i];
            acc    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (acc & g[j]);
                acc    = acc & p[j];
            end
            c[i+1] = c[i+1] | (acc & cin);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic en;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned LO = k * SW;
        localparam int unsigned HI = LO + SW;

        // a_in/b_in carry only operand bits from LO upward; r_out holds result bits below HI.
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in;
        logic                v_in;
        logic [SW-1:0]       sum;
        logic [BLOCK:0]      grp;
        logic                carry;
        logic [HI-1:0]       r_out;
        logic                vld_q;
        logic                c_q;
        logic [HI-1:0]       r_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = op[0] ? ~b : b;
            assign c_in  = op[1] ? carry_in : op[0];
            assign v_in  = in_valid;
            assign r_out = sum;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].vld_q;
            assign r_out = {sum, g_stage[k-1].r_q};
        end

        always_comb begin
            grp   = '0;
            sum   = '0;
            carry = c_in;
            for (int unsigned gi = 0; gi < PIPE_GROUPS; gi++) begin
                grp = cla_group(a_in[gi*BLOCK +: BLOCK], b_in[gi*BLOCK +: BLOCK], carry);
                sum[gi*BLOCK +: BLOCK] = grp[BLOCK-1:0];
                carry = grp[BLOCK];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                r_q   <= '0;
            end else if (en) begin
                vld_q <= v_in;
                c_q   <= carry;
                r_q   <= r_out;
            end
        end

        if (k < S - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[WIDTH-LO-1:SW];
                    b_q <= b_in[WIDTH-LO-1:SW];
                end
            end
        end else begin : g_out
            logic z_q;
            logic n_q;
            logic v_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z_q <= 1'b0;
                    n_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (en) begin
                    z_q <= ~|r_out;
                    n_q <= r_out[HI-1];
                    v_q <= (a_in[SW-1] == b_in[SW-1]) & (r_out[HI-1] != a_in[SW-1]);
                end
            end
        end
    end

    // The whole pipe advances together; bubbles are held in place during a stall.
    assign en        = ~g_stage[S-1].vld_q | out_ready;
    assign in_ready  = en;
    assign out_valid = g_stage[S-1].vld_q;
    assign result    = g_stage[S-1].r_q;
    assign flag_c    = g_stage[S-1].c_q;
    assign flag_z    = g_stage[S-1].g_out.z_q;
    assign flag_n    = g_stage[S-1].g_out.n_q;
    assign flag_v    = g_stage[S-1].g_out.v_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, reset/stall/bubble sequences on the default
// configuration, and randomized traffic on three configurations against an arithmetic model.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid_s [3];
    logic        out_ready_s[3];
    logic        carry_in_s [3];
    logic [1:0]  op_s       [3];
    logic [31:0] a_s        [3];
    logic [31:0] b_s        [3];
    logic        in_ready_s [3];
    logic        out_valid_s[3];
    logic        fc_s[3], fz_s[3], fn_s[3], fv_s[3];
    logic [15:0] res0;
    logic [31:0] res1;
    logic [7:0]  res2;

    pipelined_addsub u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0][15:0]), .b(b_s[0][15:0]), .op(op_s[0]), .carry_in(carry_in_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .result(res0),
        .flag_c(fc_s[0]), .flag_z(fz_s[0]), .flag_n(fn_s[0]), .flag_v(fv_s[0])
    );

    pipelined_addsub #(.WIDTH(32), .BLOCK(4), .PIPE_GROUPS(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .op(op_s[1]), .carry_in(carry_in_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .result(res1),
        .flag_c(fc_s[1]), .flag_z(fz_s[1]), .flag_n(fn_s[1]), .flag_v(fv_s[1])
    );

    pipelined_addsub #(.WIDTH(8), .BLOCK(4), .PIPE_GROUPS(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .op(op_s[2]), .carry_in(carry_in_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .result(res2),
        .flag_c(fc_s[2]), .flag_z(fz_s[2]), .flag_n(fn_s[2]), .flag_v(fv_s[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        c, z, n, v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int idx);
        return (idx == 0) ? 16 : (idx == 1) ? 32 : 8;
    endfunction

    function automatic int stages_of(input int idx);
        return (idx == 0) ? 2 : (idx == 1) ? 8 : 1;
    endfunction

    function automatic logic [35:0] dut_tuple(input int idx);
        logic [31:0] r;
        r = (idx == 0) ? {16'h0, res0} : (idx == 1) ? res1 : {24'h0, res2};
        return {r, fc_s[idx], fz_s[idx], fn_s[idx], fv_s[idx]};
    endfunction

    // Reference: true integer arithmetic, carry = no unsigned overflow/borrow, V = signed range.
    function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic cin);
        longint lim, half, ua, ub, sa, sb, ci, t, st;
        logic   c;
        lim  = longint'(1) << w;
        half = lim / 2;
        ua   = longint'(a) & (lim - 1);
        ub   = longint'(b) & (lim - 1);
        sa   = (ua >= half) ? ua - lim : ua;
        sb   = (ub >= half) ? ub - lim : ub;
        ci   = (op == 2'b00) ? 0 : (op == 2'b01) ? 1 : (cin ? 1 : 0);
        if (op[0] == 1'b0) begin
            t  = ua + ub + ci;
            st = sa + sb + ci;
            c  = (t >= lim);
        end else begin
            t  = ua - ub - (1 - ci);
            st = sa - sb - (1 - ci);
            c  = (t >= 0);
        end
        t = ((t % lim) + lim) % lim;
        return {32'(t), c, t == 0, t >= half, (st < -half) || (st >= half)};
    endfunction

    function automatic logic [31:0] pick_operand(input int w);
        logic [31:0] mask;
        mask = 32'((64'd1 << w) - 1);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return mask;
            2:       return 32'(64'd1 << (w - 1));
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic drive(input int idx, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic cin);
        in_valid_s[idx] = v;
        a_s[idx]        = a;
        b_s[idx]        = b;
        op_s[idx]       = op;
        carry_in_s[idx] = cin;
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            out_ready_s[0] = 1'b1;
        end
    endtask

    // Single op into an empty pipe: latency and value, then sustained random traffic.
    task automatic run_random(input int idx, input int n_ops);
        int          w, lat, got, sent;
        logic [35:0] q[$];
        logic [35:0] exp, prev;
        logic        prev_stall;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic        rcin;
        w  = width_of(idx);
        ra = pick_operand(w);
        rb = pick_operand(w);
        rop = 2'($urandom_range(0, 3));
        rcin = 1'($urandom_range(0, 1));
        @(negedge clk);
        out_ready_s[idx] = 1'b1;
        drive(idx, 1'b1, ra, rb, rop, rcin);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid_s[idx] = 1'b0;
            lat++;
            #1;
        end while (!out_valid_s[idx] && lat < 20);
        check($sformatf("latency dut%0d", idx), 64'(lat), 64'(stages_of(idx)));
        check($sformatf("first op dut%0d", idx), 64'(dut_tuple(idx)), 64'(model(w, ra, rb, rop, rcin)));

        got = 0;
        sent = 0;
        prev_stall = 1'b0;
        prev = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < n_ops * 4 && got < n_ops; cyc++) begin
            @(negedge clk);
            if (sent < n_ops && $urandom_range(0, 9) < 8)
                drive(idx, 1'b1, pick_operand(w), pick_operand(w), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            else
                in_valid_s[idx] = 1'b0;
            out_ready_s[idx] = ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall)
                check($sformatf("stall hold dut%0d", idx), {27'h0, out_valid_s[idx], dut_tuple(idx)},
                      {27'h0, 1'b1, prev});
            if (out_valid_s[idx] && out_ready_s[idx]) begin
                if (q.size() == 0) begin
                    check($sformatf("spurious output dut%0d", idx), 64'd1, 64'd0);
                end else begin
                    exp = q.pop_front();
                    check($sformatf("random result dut%0d", idx), 64'(dut_tuple(idx)), 64'(exp));
                end
                got++;
            end
            prev_stall = out_valid_s[idx] && !out_ready_s[idx];
            prev = dut_tuple(idx);
            if (in_valid_s[idx] && in_ready_s[idx]) begin
                q.push_back(model(w, a_s[idx], b_s[idx], op_s[idx], carry_in_s[idx]));
                sent++;
            end
        end
        check($sformatf("random count dut%0d", idx), 64'(got), 64'(n_ops));
        check($sformatf("random leftover dut%0d", idx), 64'(q.size()), 64'd0);
        @(negedge clk);
        in_valid_s[idx] = 1'b0;
        out_ready_s[idx] = 1'b1;
    endtask

    initial begin
        int          lat, sent, got, nv;
        logic [35:0] held;
        logic [35:0] bp_exp[6];
        logic [15:0] bp_a[6];
        logic [15:0] bp_b[6];
        logic [1:0]  bp_op[6];
        logic        bp_cin[6];
        logic        hist[8];

        vecs[0] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 16'h0010, 16'h0001, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            out_ready_s[i] = 1'b1;
        end

        @(negedge clk);
        #1;
        check("reset out_valid", 64'(out_valid_s[0]), 64'd0);
        check("reset result/flags", 64'(dut_tuple(0)), 64'd0);
        check("reset in_ready", 64'(in_ready_s[0]), 64'd1);
        rst_n = 1'b1;

        // Directed vectors, one at a time into an empty pipe.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].op, vecs[i].cin);
            lat = 0;
            do begin
                @(negedge clk);
                in_valid_s[0] = 1'b0;
                lat++;
                #1;
            end while (!out_valid_s[0] && lat < 10);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d result/flags", i), 64'(dut_tuple(0)),
                  64'({16'h0, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v}));
        end
        flush(3);

        // Reset with two operations in flight and the output stalled.
        @(negedge clk);
        out_ready_s[0] = 1'b0;
        drive(0, 1'b1, 32'h1234, 32'h1111, 2'b00, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 32'h4321, 32'h0101, 2'b01, 1'b0);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        #1;
        check("pre-reset out_valid", 64'(out_valid_s[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 64'(out_valid_s[0]), 64'd0);
        check("mid reset result/flags", 64'(dut_tuple(0)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_s[0] = 1'b1;
        #1;
        check("post reset in_ready", 64'(in_ready_s[0]), 64'd1);
        nv = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            #1;
            if (out_valid_s[0]) nv++;
        end
        check("post reset stale outputs", 64'(nv), 64'd0);

        // Backpressure: six back-to-back ops, output stalled for four cycles after the first.
        for (int i = 0; i < 6; i++) begin
            bp_a[i]   = 16'($urandom);
            bp_b[i]   = 16'($urandom);
            bp_op[i]  = 2'($urandom_range(0, 3));
            bp_cin[i] = 1'($urandom_range(0, 1));
            bp_exp[i] = model(16, 32'(bp_a[i]), 32'(bp_b[i]), bp_op[i], bp_cin[i]);
        end
        sent = 0;
        got = 0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (sent < 6) drive(0, 1'b1, 32'(bp_a[sent]), 32'(bp_b[sent]), bp_op[sent], bp_cin[sent]);
            else in_valid_s[0] = 1'b0;
            out_ready_s[0] = !(cyc >= 2 && cyc <= 5);
            #1;
            if (cyc == 2) begin
                check("bp first result valid", 64'(out_valid_s[0]), 64'd1);
                held = dut_tuple(0);
            end
            if (cyc >= 2 && cyc <= 5) begin
                check($sformatf("bp in_ready cyc%0d", cyc), 64'(in_ready_s[0]), 64'd0);
                if (cyc > 2) check($sformatf("bp held cyc%0d", cyc), 64'(dut_tuple(0)), 64'(held));
            end
            if (out_valid_s[0] && out_ready_s[0]) begin
                check($sformatf("bp result %0d", got), 64'(dut_tuple(0)), 64'(bp_exp[got]));
                got++;
            end
            if (in_valid_s[0] && in_ready_s[0]) sent++;
        end
        check("bp results delivered", 64'(got), 64'd6);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        #1;
        check("bp no duplicate", 64'(out_valid_s[0]), 64'd0);
        flush(3);

        // Bubbles: in_valid 1,0,1,0 must reappear on out_valid two cycles later.
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            hist[cyc] = (cyc < 4) && (cyc % 2 == 0);
            drive(0, hist[cyc], 32'(cyc + 1), 32'h3, 2'b00, 1'b0);
            out_ready_s[0] = 1'b1;
            #1;
            check($sformatf("bubble out_valid cyc%0d", cyc), 64'(out_valid_s[0]),
                  (cyc >= 2) ? 64'(hist[cyc-2]) : 64'd0);
        end
        flush(3);

        run_random(0, 3000);
        run_random(1, 10000);
        run_random(2, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
